// File: rtl/if_stage_pkg.sv
// Shared constants for the instruction-fetch stage: IF->ID bus width and FSM state encodings.
package if_stage_pkg;

  localparam int IF_TO_ID_BUS_WIDTH = 65;
  localparam int IF_STATE_WIDTH     = 2;

  typedef enum logic [IF_STATE_WIDTH-1:0] {
    IF_STATE_BOOT  = 2'd0,
    IF_STATE_FETCH = 2'd1,
    IF_STATE_STALL = 2'd2
  } if_state_e;

endpackage

// File: rtl/if_stage_perf_cnt.sv
// Saturating fetch/stall performance counters for the IF stage.
// Only built when IF_PERF_CNT_EN is defined.
`ifdef IF_PERF_CNT_EN
module if_perf_cnt (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_inc_i,
  input  logic        stall_inc_i,
  output logic [31:0] fetch_cnt_o,
  output logic [31:0] stall_cnt_o
);

  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Counters stick at all-ones instead of wrapping.
  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (fetch_inc_i && (fetch_cnt_q != 32'hFFFF_FFFF)) fetch_cnt_d = fetch_cnt_q + 32'd1;
    if (stall_inc_i && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt_q <= 32'd0;
      stall_cnt_q <= 32'd0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign fetch_cnt_o = fetch_cnt_q;
  assign stall_cnt_o = stall_cnt_q;

endmodule
`endif

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives IROM address, hands {pc4, pc, int_flag} to ID.
// Optional performance counters are enabled with IF_PERF_CNT_EN.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          br_taken,
  input  logic [31:0]                   br_target,
  input  logic                          int_assert,
  input  logic [31:0]                   int_addr,
  input  logic                          hold_flag_if,
  input  logic                          id_allow_in,
  output logic [31:0]                   irom_addr,
  output logic [IF_TO_ID_BUS_WIDTH-1:0] if_to_id_bus,
  output logic                          if_to_id_valid
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]                   fetch_cnt,
  output logic [31:0]                   stall_cnt
`endif
);

  if_state_e   state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        int_flag_q, int_flag_d;
  logic [31:0] pc4;
  logic        if_valid;
  logic        xfer;

  assign if_valid       = (state_q != IF_STATE_BOOT);
  assign pc4            = pc_q + 32'd4;
  assign if_to_id_valid = if_valid && !hold_flag_if && !br_taken && !int_assert;
  assign xfer           = if_to_id_valid && id_allow_in;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IF_STATE_BOOT:  state_d = IF_STATE_FETCH;
      IF_STATE_FETCH: if (hold_flag_if) state_d = IF_STATE_STALL;
      IF_STATE_STALL: if (!hold_flag_if) state_d = IF_STATE_FETCH;
      default:        state_d = IF_STATE_BOOT;
    endcase
  end

  // CLINT redirect beats branch, which beats sequential advance; redirects apply even in BOOT/STALL.
  always_comb begin
    pc_d       = pc_q;
    int_flag_d = int_flag_q;
    if (int_assert) begin
      pc_d       = int_addr & ~32'h3;
      int_flag_d = 1'b1;
    end else if (br_taken) begin
      pc_d       = br_target & ~32'h3;
      int_flag_d = 1'b0;
    end else if (xfer) begin
      pc_d       = pc4;
      int_flag_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IF_STATE_BOOT;
      pc_q       <= RESET_PC;
      int_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      int_flag_q <= int_flag_d;
    end
  end

  assign irom_addr    = pc_q;
  assign if_to_id_bus = {pc4, pc_q, int_flag_q};

`ifdef IF_PERF_CNT_EN
  if_perf_cnt u_perf_cnt (
    .clk         (clk),
    .rst         (rst),
    .fetch_inc_i (xfer),
    .stall_inc_i (if_valid && !xfer && !br_taken && !int_assert),
    .fetch_cnt_o (fetch_cnt),
    .stall_cnt_o (stall_cnt)
  );
`endif

endmodule

// File: tb/tb_if_stage.sv
// Directed self-checking bench for if_stage; expectations are queued when stimulus is driven
// and popped at the following negedge sample.
module tb_if_stage;
  import if_stage_pkg::*;

  logic                          clk;
  logic                          rst;
  logic                          br_taken;
  logic [31:0]                   br_target;
  logic                          int_assert;
  logic [31:0]                   int_addr;
  logic                          hold_flag_if;
  logic                          id_allow_in;
  logic [31:0]                   irom_addr;
  logic [IF_TO_ID_BUS_WIDTH-1:0] if_to_id_bus;
  logic                          if_to_id_valid;
`ifdef IF_PERF_CNT_EN
  logic [31:0]                   fetch_cnt;
  logic [31:0]                   stall_cnt;
`endif

  typedef struct {
    logic        valid;
    logic [31:0] pc;
    logic        flag;
  } exp_t;

  exp_t scoreboard[$];
  int   compared   = 0;
  int   mismatched = 0;

  if_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst            (rst),
    .br_taken       (br_taken),
    .br_target      (br_target),
    .int_assert     (int_assert),
    .int_addr       (int_addr),
    .hold_flag_if   (hold_flag_if),
    .id_allow_in    (id_allow_in),
    .irom_addr      (irom_addr),
    .if_to_id_bus   (if_to_id_bus),
    .if_to_id_valid (if_to_id_valid)
`ifdef IF_PERF_CNT_EN
    ,
    .fetch_cnt      (fetch_cnt),
    .stall_cnt      (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkValue(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Pops the oldest expectation and compares it against the live outputs.
  task automatic checkOutput(input string tag);
    exp_t e;
    if (scoreboard.size() == 0) begin
      checkValue({tag, "_sb_empty"}, 65'd0, 65'd1);
    end else begin
      e = scoreboard.pop_front();
      checkValue({tag, "_valid"}, {64'd0, if_to_id_valid}, {64'd0, e.valid});
      checkValue({tag, "_pc"}, {33'd0, irom_addr}, {33'd0, e.pc});
      if (e.valid)
        checkValue({tag, "_bus"}, if_to_id_bus, {e.pc + 32'd4, e.pc, e.flag});
    end
  endtask

  // Drives one cycle of inputs just after a posedge, samples at the negedge, then returns after the next posedge.
  task automatic applyStimulus(input string tag, input logic br, input logic [31:0] tgt,
                               input logic intA, input logic [31:0] iaddr, input logic hold,
                               input logic allow, input logic expValid, input logic [31:0] expPc,
                               input logic expFlag);
    exp_t e;
    br_taken     = br;
    br_target    = tgt;
    int_assert   = intA;
    int_addr     = iaddr;
    hold_flag_if = hold;
    id_allow_in  = allow;
    e.valid = expValid;
    e.pc    = expPc;
    e.flag  = expFlag;
    scoreboard.push_back(e);
    @(negedge clk);
    checkOutput(tag);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    br_taken = 1'b0; br_target = '0; int_assert = 1'b0; int_addr = '0;
    hold_flag_if = 1'b0; id_allow_in = 1'b1;
    @(posedge clk); #1;
    applyStimulus("reset", 0, 0, 0, 0, 0, 1, 0, 32'h0, 0);
`ifdef IF_PERF_CNT_EN
    checkValue("rst_fetch_cnt", {33'd0, fetch_cnt}, 65'd0);
    checkValue("rst_stall_cnt", {33'd0, stall_cnt}, 65'd0);
`endif
    rst = 1'b0;

    applyStimulus("boot",   0, 0, 0, 0, 0, 1, 0, 32'h0, 0);
    applyStimulus("seq0",   0, 0, 0, 0, 0, 1, 1, 32'h0, 0);
    applyStimulus("seq4",   0, 0, 0, 0, 0, 1, 1, 32'h4, 0);
    applyStimulus("bp1",    0, 0, 0, 0, 0, 0, 1, 32'h8, 0);
    applyStimulus("bp2",    0, 0, 0, 0, 0, 0, 1, 32'h8, 0);
    applyStimulus("bp3",    0, 0, 0, 0, 0, 0, 1, 32'h8, 0);
`ifdef IF_PERF_CNT_EN
    checkValue("bp_stall_cnt", {33'd0, stall_cnt}, 65'd3);
    checkValue("bp_fetch_cnt", {33'd0, fetch_cnt}, 65'd2);
`endif
    applyStimulus("seq8",   0, 0, 0, 0, 0, 1, 1, 32'h8, 0);
    applyStimulus("seqC",   0, 0, 0, 0, 0, 1, 1, 32'hC, 0);
    applyStimulus("br",     1, 32'h103, 0, 0, 0, 1, 0, 32'h10, 0);
    applyStimulus("br_tgt", 0, 0, 0, 0, 0, 1, 1, 32'h100, 0);
    applyStimulus("int_br", 1, 32'h200, 1, 32'h80, 0, 1, 0, 32'h104, 0);
    applyStimulus("int_bp", 0, 0, 0, 0, 0, 0, 1, 32'h80, 1);
    applyStimulus("int_x",  0, 0, 0, 0, 0, 1, 1, 32'h80, 1);
    applyStimulus("int_nx", 0, 0, 0, 0, 0, 0, 1, 32'h84, 0);
    applyStimulus("hold1",  0, 0, 0, 0, 1, 1, 0, 32'h84, 0);
    applyStimulus("hold2",  1, 32'h40, 0, 0, 1, 1, 0, 32'h84, 0);
    applyStimulus("hold_r", 0, 0, 0, 0, 0, 1, 1, 32'h40, 0);
    applyStimulus("br_top", 1, 32'hFFFF_FFFC, 0, 0, 0, 1, 0, 32'h44, 0);
    applyStimulus("wrap",   0, 0, 0, 0, 0, 1, 1, 32'hFFFF_FFFC, 0);
    applyStimulus("wrap0",  0, 0, 0, 0, 0, 1, 1, 32'h0, 0);

    // Mid-stream asynchronous reset: sample before and shortly after rst rises, away from any edge.
    begin
      exp_t e;
      e.valid = 1'b1; e.pc = 32'h4; e.flag = 1'b0;
      scoreboard.push_back(e);
      @(negedge clk);
      checkOutput("pre_rst");
      #1 rst = 1'b1;
      e.valid = 1'b0; e.pc = 32'h0; e.flag = 1'b0;
      scoreboard.push_back(e);
      #1 checkOutput("async_rst");
`ifdef IF_PERF_CNT_EN
      checkValue("async_rst_cnt", {33'd0, fetch_cnt}, 65'd0);
`endif
      @(posedge clk); #1;
    end
    rst = 1'b0;
    applyStimulus("reboot", 0, 0, 0, 0, 0, 1, 0, 32'h0, 0);
    applyStimulus("refetch",0, 0, 0, 0, 0, 1, 1, 32'h0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
